mem_access_stage: RTL and testbench

- MEM-stage data-memory access controller between the EX/MEM pipeline register and the MEM/WB register.
- Converts EX/MEM load/store controls into a req/ack transaction on a variable-latency data-memory port.
- Generates byte enables and lane-replicated store data; aligns and sign/zero-extends load data.
- Stalls the pipeline until the access completes, then presents DataMemoryReadData and DataMemoryAddress to MEM/WB.

---
 rtl/mips_mem_pkg.sv | 38 +++
 rtl/load_align_ext.sv | 49 ++++
 rtl/mem_access_stage.sv | 216 +++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage data-memory access path.
//
// Contents:
//   MEM_BYTE / MEM_HALF / MEM_WORD  - EX/MEM access-size encodings
//                                     (2'b11 is handled like a word)
//   memState_e                      - access controller FSM states
//   DEFAULT_TIMEOUT_CYCLES          - default WAIT abort limit
//   DEFAULT_ERR_RDATA               - read data returned by an aborted load
//   isMisaligned()                  - alignment check shared by the stage
package mips_mem_pkg;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;
  localparam logic [31:0] DEFAULT_ERR_RDATA      = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } memState_e;

  // Halfwords must sit on an even address, words on a multiple of four.
  // Bytes can never be misaligned.
  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] lane);
    logic result;
    result = 1'b0;
    case (size)
      MEM_HALF:        result = lane[0];
      MEM_WORD, 2'b11: result = (lane != 2'b00);
      default:         result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/load_align_ext.sv
// Load data alignment and extension for the MEM stage.
//
// Picks the addressed byte or halfword out of a raw 32-bit memory word and
// sign- or zero-extends it to 32 bits. Purely combinational.
//
// Ports:
//   rdata_i     in  32  raw word returned by data memory
//   lane_i      in  2   low two bits of the effective byte address
//   size_i      in  2   access size (byte/half/word, 2'b11 = word)
//   unsigned_i  in  1   zero-extend instead of sign-extend
//   data_o      out 32  aligned, extended load result
module load_align_ext
  import mips_mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  // Byte lane follows both address bits; halfword lane only the upper one
  // since halfwords are already known to be aligned.
  always_comb begin
    byteSel = rdata_i[7:0];
    case (lane_i)
      2'd0:    byteSel = rdata_i[7:0];
      2'd1:    byteSel = rdata_i[15:8];
      2'd2:    byteSel = rdata_i[23:16];
      default: byteSel = rdata_i[31:24];
    endcase
    halfSel = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  // Fill the upper bits with the selected value's MSB unless the load is
  // an unsigned variant (lbu/lhu).
  always_comb begin
    data_o = rdata_i;
    case (size_i)
      MEM_BYTE: data_o = {{24{~unsigned_i & byteSel[7]}}, byteSel};
      MEM_HALF: data_o = {{16{~unsigned_i & halfSel[15]}}, halfSel};
      default:  data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage data-memory access controller.
//
// Turns EX/MEM load/store controls into a req/ack transaction on a
// variable-latency data-memory port, stalls the pipeline while the access
// is in flight, and hands the extended load result to MEM/WB.
//
// Optional feature: define DMEM_TIMEOUT_EN to abort a WAIT that sees no ack
// within TIMEOUT_CYCLES cycles (a timed-out load returns ERR_RDATA). Without
// it, WAIT holds until ack arrives.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   EX_MEM_MemRead/MemWrite  load / store present in MEM (write wins)
//   EX_MEM_MemSize           00 byte, 01 half, 10/11 word
//   EX_MEM_MemUnsigned       zero-extend loads
//   EX_MEM_ALUResult         effective byte address
//   EX_MEM_WriteData         store data
//   dmem_req/we/addr/be/wdata  registered memory request
//   dmem_ack, dmem_rdata     memory completion and raw read word
//   DataMemoryReadData       registered, extended load result
//   DataMemoryAddress        pass-through of EX_MEM_ALUResult
//   mem_stall                freeze upstream pipeline, hold MEM/WB
//   misaligned_exc           misaligned access flag
module mem_access_stage
  import mips_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter logic [31:0] ERR_RDATA      = DEFAULT_ERR_RDATA
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        EX_MEM_MemRead,
  input  logic        EX_MEM_MemWrite,
  input  logic [1:0]  EX_MEM_MemSize,
  input  logic        EX_MEM_MemUnsigned,
  input  logic [31:0] EX_MEM_ALUResult,
  input  logic [31:0] EX_MEM_WriteData,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] DataMemoryReadData,
  output logic [31:0] DataMemoryAddress,
  output logic        mem_stall,
  output logic        misaligned_exc
);

  memState_e stateQ, stateD;

  logic        accessReq;
  logic        misaligned;
  logic        startAccess;
  logic        finishWait;
  logic        timeoutHit;
  logic [3:0]  storeBe;
  logic [31:0] storeWdata;
  logic [31:0] alignedData;

  logic        dmemReqQ;
  logic        dmemWeQ;
  logic [31:0] dmemAddrQ;
  logic [3:0]  dmemBeQ;
  logic [31:0] dmemWdataQ;
  logic [1:0]  laneQ;
  logic [1:0]  sizeQ;
  logic        unsignedQ;
  logic [31:0] readDataQ;

  assign accessReq   = EX_MEM_MemRead | EX_MEM_MemWrite;
  assign misaligned  = isMisaligned(EX_MEM_MemSize, EX_MEM_ALUResult[1:0]);
  assign startAccess = (stateQ == IDLE) && accessReq && !misaligned;
  assign finishWait  = (stateQ == WAIT) && (dmem_ack || timeoutHit);

`ifdef DMEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] waitCntQ, waitCntD;

  // Counter reads 0 in the first WAIT cycle, so the Nth WAIT cycle sees
  // N-1. An ack in the same cycle as the limit wins.
  assign timeoutHit = (stateQ == WAIT) && !dmem_ack &&
                      (waitCntQ == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    waitCntD = '0;
    if (stateQ == WAIT) begin
      waitCntD = waitCntQ + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      waitCntQ <= '0;
    end else begin
      waitCntQ <= waitCntD;
    end
  end
`else
  logic unusedTimeoutCycles;

  assign timeoutHit          = 1'b0;
  assign unusedTimeoutCycles = (TIMEOUT_CYCLES != 0);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ <= IDLE;
    end else begin
      stateQ <= stateD;
    end
  end

  // Next-state logic. DONE always returns to IDLE so that the access still
  // sitting on EX/MEM during DONE is not started a second time.
  always_comb begin
    stateD = stateQ;
    case (stateQ)
      IDLE:    if (startAccess) stateD = WAIT;
      WAIT:    if (finishWait)  stateD = DONE;
      DONE:    stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  // FSM outputs. The stall is raised combinationally in IDLE so the
  // pipeline freezes in the same cycle the access is first seen.
  always_comb begin
    mem_stall      = 1'b0;
    misaligned_exc = 1'b0;
    case (stateQ)
      IDLE: begin
        mem_stall      = accessReq && !misaligned;
        misaligned_exc = accessReq && misaligned;
      end
      WAIT:    mem_stall = 1'b1;
      default: begin
        mem_stall      = 1'b0;
        misaligned_exc = 1'b0;
      end
    endcase
  end

  // Store lane placement: data is replicated across every lane it could
  // occupy and the byte enables pick the lane(s) actually written.
  always_comb begin
    storeBe    = 4'b1111;
    storeWdata = EX_MEM_WriteData;
    case (EX_MEM_MemSize)
      MEM_BYTE: begin
        storeBe    = 4'b0001 << EX_MEM_ALUResult[1:0];
        storeWdata = {4{EX_MEM_WriteData[7:0]}};
      end
      MEM_HALF: begin
        storeBe    = EX_MEM_ALUResult[1] ? 4'b1100 : 4'b0011;
        storeWdata = {2{EX_MEM_WriteData[15:0]}};
      end
      default: begin
        storeBe    = 4'b1111;
        storeWdata = EX_MEM_WriteData;
      end
    endcase
  end

  load_align_ext u_load_align_ext (
    .rdata_i    (dmem_rdata),
    .lane_i     (laneQ),
    .size_i     (sizeQ),
    .unsigned_i (unsignedQ),
    .data_o     (alignedData)
  );

  // Request registers are captured once on entry to WAIT and held stable
  // for the whole transaction. Lane, size and signedness are captured too
  // so load extraction does not depend on the frozen EX/MEM inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      dmemReqQ   <= 1'b0;
      dmemWeQ    <= 1'b0;
      dmemAddrQ  <= '0;
      dmemBeQ    <= '0;
      dmemWdataQ <= '0;
      laneQ      <= '0;
      sizeQ      <= '0;
      unsignedQ  <= 1'b0;
      readDataQ  <= '0;
    end else begin
      dmemReqQ <= (stateD == WAIT);
      if (startAccess) begin
        dmemWeQ    <= EX_MEM_MemWrite;
        dmemAddrQ  <= {EX_MEM_ALUResult[31:2], 2'b00};
        dmemBeQ    <= storeBe;
        dmemWdataQ <= storeWdata;
        laneQ      <= EX_MEM_ALUResult[1:0];
        sizeQ      <= EX_MEM_MemSize;
        unsignedQ  <= EX_MEM_MemUnsigned;
      end
      if (finishWait && !dmemWeQ) begin
        readDataQ <= dmem_ack ? alignedData : ERR_RDATA;
      end
    end
  end

  assign dmem_req           = dmemReqQ;
  assign dmem_we            = dmemWeQ;
  assign dmem_addr          = dmemAddrQ;
  assign dmem_be            = dmemBeQ;
  assign dmem_wdata         = dmemWdataQ;
  assign DataMemoryReadData = readDataQ;
  assign DataMemoryAddress  = EX_MEM_ALUResult;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed transactions followed
// by randomized ones, all compared against a transaction-level model.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        memRead, memWrite, memUnsigned;
  logic [1:0]  memSize;
  logic [31:0] aluResult, writeData;
  logic        dmemReq, dmemWe, dmemAck;
  logic [31:0] dmemAddr, dmemWdata, dmemRdata;
  logic [3:0]  dmemBe;
  logic [31:0] readData, dataAddr;
  logic        memStall, misalignedExc;

  int checks = 0;
  int errors = 0;

  // Load result the pipeline should currently see on DataMemoryReadData.
  logic [31:0] modelReadData;

  always #5 clk = ~clk;

  mem_access_stage #(
    .TIMEOUT_CYCLES (16),
    .ERR_RDATA      (32'hDEAD_BEEF)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .EX_MEM_MemRead     (memRead),
    .EX_MEM_MemWrite    (memWrite),
    .EX_MEM_MemSize     (memSize),
    .EX_MEM_MemUnsigned (memUnsigned),
    .EX_MEM_ALUResult   (aluResult),
    .EX_MEM_WriteData   (writeData),
    .dmem_req           (dmemReq),
    .dmem_we            (dmemWe),
    .dmem_addr          (dmemAddr),
    .dmem_be            (dmemBe),
    .dmem_wdata         (dmemWdata),
    .dmem_ack           (dmemAck),
    .dmem_rdata         (dmemRdata),
    .DataMemoryReadData (readData),
    .DataMemoryAddress  (dataAddr),
    .mem_stall          (memStall),
    .misaligned_exc     (misalignedExc)
  );

  // Reference model: plain arithmetic on byte offsets.
  function automatic bit modelMisaligned(input logic [1:0] sz, input logic [31:0] addr);
    if (sz == 2'd1) return (addr % 2) != 0;
    if (sz >= 2'd2) return (addr % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] modelBe(input logic [1:0] sz, input logic [31:0] addr);
    if (sz == 2'd0) return 4'(1 << (addr % 4));
    if (sz == 2'd1) return 4'(3 << (addr % 4));
    return 4'hF;
  endfunction

  function automatic logic [31:0] modelWdata(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'd0) return (wd & 32'hFF) * 32'h0101_0101;
    if (sz == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [1:0] sz, input bit uns,
                                            input logic [31:0] addr, input logic [31:0] raw);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (raw >> (8 * (addr % 4))) & 32'hFF;
      if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
      return v;
    end
    if (sz == 2'd1) begin
      v = (raw >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
      if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
      return v;
    end
    return raw;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                               input logic [31:0] addr, input logic [31:0] wd);
    memRead     = rd;
    memWrite    = wr;
    memSize     = sz;
    memUnsigned = uns;
    aluResult   = addr;
    writeData   = wd;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Drives one access from IDLE through to the following IDLE. Entered and
  // left at 1 time unit after a rising edge, with the DUT in IDLE.
  task automatic runAccess(input string tag, input bit rd, input bit wr, input logic [1:0] sz,
                           input bit uns, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] raw, input int ackDelay);
    int stalls;
    applyStimulus(rd, wr, sz, uns, addr, wd);
    dmemAck = 1'b0;
    #1;
    checkOutput({tag, ".addrPass"}, dataAddr, addr);
    if (modelMisaligned(sz, addr)) begin
      checkOutput({tag, ".misExc"}, 32'(misalignedExc), 32'd1);
      checkOutput({tag, ".misStall"}, 32'(memStall), 32'd0);
      nextCycle();
      applyStimulus(0, 0, 2'd0, 0, 32'h0, 32'h0);
      #1;
      checkOutput({tag, ".misNoReq"}, 32'(dmemReq), 32'd0);
      checkOutput({tag, ".misExcGone"}, 32'(misalignedExc), 32'd0);
      checkOutput({tag, ".misRdHold"}, readData, modelReadData);
      return;
    end
    checkOutput({tag, ".noExc"}, 32'(misalignedExc), 32'd0);
    stalls = (memStall === 1'b1) ? 1 : 0;
    nextCycle();
    checkOutput({tag, ".req"}, 32'(dmemReq), 32'd1);
    checkOutput({tag, ".we"}, 32'(dmemWe), 32'(wr));
    checkOutput({tag, ".addr"}, dmemAddr, addr & 32'hFFFF_FFFC);
    checkOutput({tag, ".be"}, 32'(dmemBe), 32'(modelBe(sz, addr)));
    if (wr) checkOutput({tag, ".wdata"}, dmemWdata, modelWdata(sz, wd));
    for (int i = 0; i <= ackDelay; i++) begin
      dmemAck   = (i == ackDelay);
      dmemRdata = (i == ackDelay) ? raw : $urandom;
      #1;
      if (memStall === 1'b1) stalls++;
      checkOutput({tag, ".reqHeld"}, 32'(dmemReq), 32'd1);
      nextCycle();
    end
    dmemAck   = 1'b0;
    dmemRdata = $urandom;
    #1;
    if (rd && !wr) modelReadData = modelLoad(sz, uns, addr, raw);
    checkOutput({tag, ".doneStall"}, 32'(memStall), 32'd0);
    checkOutput({tag, ".doneReq"}, 32'(dmemReq), 32'd0);
    checkOutput({tag, ".rdata"}, readData, modelReadData);
    checkOutput({tag, ".stallCycles"}, 32'(stalls), 32'(2 + ackDelay));
    nextCycle();
    applyStimulus(0, 0, 2'd0, 0, 32'h0, 32'h0);
    #1;
    checkOutput({tag, ".idleReq"}, 32'(dmemReq), 32'd0);
    checkOutput({tag, ".idleStall"}, 32'(memStall), 32'd0);
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] addr;
    bit          rd, wr;

    rst           = 1'b1;
    dmemAck       = 1'b0;
    dmemRdata     = 32'h0;
    modelReadData = 32'h0;
    applyStimulus(0, 0, 2'd0, 0, 32'h0, 32'h0);
    nextCycle();
    nextCycle();
    rst = 1'b0;
    #1;
    checkOutput("reset.req", 32'(dmemReq), 32'd0);
    checkOutput("reset.we", 32'(dmemWe), 32'd0);
    checkOutput("reset.be", 32'(dmemBe), 32'd0);
    checkOutput("reset.addr", dmemAddr, 32'h0);
    checkOutput("reset.wdata", dmemWdata, 32'h0);
    checkOutput("reset.rdata", readData, 32'h0);
    checkOutput("reset.stall", 32'(memStall), 32'd0);
    checkOutput("reset.exc", 32'(misalignedExc), 32'd0);

    // Directed transactions.
    runAccess("lw100", 1, 0, 2'd2, 0, 32'h100, 32'h0, 32'h1234_5678, 0);
    runAccess("lb103", 1, 0, 2'd0, 0, 32'h103, 32'h0, 32'h80FF_FFFF, 1);
    runAccess("lbu103", 1, 0, 2'd0, 1, 32'h103, 32'h0, 32'h80FF_FFFF, 0);
    runAccess("sh102", 0, 1, 2'd1, 0, 32'h102, 32'h0000_ABCD, 32'h0, 4);
    runAccess("lw101", 1, 0, 2'd2, 0, 32'h101, 32'h0, 32'h0, 0);
    runAccess("lh106", 1, 0, 2'd1, 0, 32'h106, 32'h0, 32'h8001_7F00, 2);
    runAccess("lhu106", 1, 0, 2'd1, 1, 32'h106, 32'h0, 32'h8001_7F00, 0);
    runAccess("sb201", 0, 1, 2'd0, 0, 32'h201, 32'h1234_56A5, 32'h0, 1);
    runAccess("rdwr104", 1, 1, 2'd2, 0, 32'h104, 32'hCAFE_F00D, 32'h5555_5555, 0);
    runAccess("lw3_108", 1, 0, 2'd3, 0, 32'h108, 32'h0, 32'h0BAD_F00D, 0);
    runAccess("sh203", 0, 1, 2'd1, 0, 32'h203, 32'h1111_2222, 32'h0, 0);

    // Stray ack while idle must not touch the load result.
    dmemAck   = 1'b1;
    dmemRdata = 32'hFFFF_FFFF;
    nextCycle();
    dmemAck = 1'b0;
    #1;
    checkOutput("idleAck.rdata", readData, modelReadData);
    checkOutput("idleAck.req", 32'(dmemReq), 32'd0);

    // Reset while a load waits, then a late ack.
    applyStimulus(1, 0, 2'd2, 0, 32'h300, 32'h0);
    nextCycle();
    checkOutput("rstWait.req", 32'(dmemReq), 32'd1);
    rst = 1'b1;
    applyStimulus(0, 0, 2'd0, 0, 32'h0, 32'h0);
    nextCycle();
    rst           = 1'b0;
    modelReadData = 32'h0;
    #1;
    checkOutput("rstWait.reqGone", 32'(dmemReq), 32'd0);
    checkOutput("rstWait.rdata", readData, 32'h0);
    checkOutput("rstWait.stall", 32'(memStall), 32'd0);
    dmemAck   = 1'b1;
    dmemRdata = 32'h7777_7777;
    nextCycle();
    dmemAck = 1'b0;
    #1;
    checkOutput("rstLateAck.rdata", readData, 32'h0);
    checkOutput("rstLateAck.req", 32'(dmemReq), 32'd0);

`ifdef DMEM_TIMEOUT_EN
    // No ack: the request is abandoned after 16 WAIT cycles.
    applyStimulus(1, 0, 2'd2, 0, 32'h400, 32'h0);
    nextCycle();
    for (int i = 0; i < 16; i++) begin
      checkOutput("timeout.reqHeld", 32'(dmemReq), 32'd1);
      nextCycle();
    end
    modelReadData = 32'hDEAD_BEEF;
    checkOutput("timeout.req", 32'(dmemReq), 32'd0);
    checkOutput("timeout.stall", 32'(memStall), 32'd0);
    checkOutput("timeout.rdata", readData, modelReadData);
    nextCycle();
    applyStimulus(0, 0, 2'd0, 0, 32'h0, 32'h0);
    #1;
`endif

    // Randomized transactions.
    for (int n = 0; n < 40; n++) begin
      sz   = 2'($urandom_range(0, 3));
      addr = $urandom;
      rd   = 1'($urandom_range(0, 1));
      wr   = 1'($urandom_range(0, 1));
      if (!rd && !wr) rd = 1'b1;
      runAccess("rand", rd, wr, sz, 1'($urandom_range(0, 1)), addr, $urandom, $urandom,
                $urandom_range(0, 5));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
